ram_sp_param: RTL and testbench
===============================

RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter ADDR_W, default 8, address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-003 Parameter WR_THRU, default 1; 1 = a write also drives the merged word onto dataout, 0 = a write leaves dataout unchanged.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  request enable; no operation is performed when low.
REQ-007 write  input  1  write request, qualified by en.
REQ-008 read  input  1  read request, qualified by en.
REQ-009 address  input  ADDR_W  word address.
REQ-010 datain  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte enables; be[i] covers datain[8i+7:8i].
REQ-012 clr  input  1  single-cycle request to re-run the zero-fill sweep.
REQ-013 err_clr  input  1  clears both err bits.
REQ-014 dataout  output  DATA_W  registered read/write-through data; never high impedance.
REQ-015 dout_valid  output  1  one-cycle pulse marking a new dataout value.
REQ-016 busy  output  1  high while the zero-fill sweep runs.
REQ-017 err  output  2  sticky flags; err[0] = read/write collision, err[1] = request dropped while busy.

Function
REQ-018 FSM states: CLEAR and READY; reset SHALL enter CLEAR with the sweep pointer at 0.
REQ-019 CLEAR: each cycle, write 0 to mem[ptr] and increment ptr; at ptr = DEPTH-1, write 0 and go to READY on the same edge.
REQ-020 busy SHALL be 1 in CLEAR and 0 in READY; the sweep SHALL take exactly DEPTH cycles.
REQ-021 READY with clr=1: go to CLEAR with ptr=0; a clr during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-022 READY with clr=1 and a simultaneous en request: clr wins, the request is dropped, and err[1] is set.
REQ-023 Write (READY, en=1, write=1, read=0): for every i with be[i]=1, byte i of mem[address] takes byte i of datain; the other bytes keep their old value.
REQ-024 If WR_THRU=1, a write SHALL load dataout with the full merged word (new mem[address]) and pulse dout_valid.
REQ-025 Read (READY, en=1, write=0, read=1): dataout takes mem[address] at the same edge, giving 1-cycle latency, and dout_valid=1 for that one following cycle.
REQ-026 A write and a read on consecutive cycles to the same address: the read SHALL return the newly written data.
REQ-027 Collision (en=1, write=1, read=1): no memory change, dataout holds, dout_valid=0, err[0] set.
REQ-028 Any en=1 request with write=1 or read=1 while busy=1 SHALL be dropped and SHALL set err[1].
REQ-029 en=1 with write=0 and read=0 is a no-op with no error.
REQ-030 dataout SHALL hold its last value whenever dout_valid=0.
REQ-031 err bits SHALL stay set until err_clr=1; when err_clr and a new error event occur on the same edge, the new error wins.
REQ-032 be=0 on a write: memory is unchanged and the access still counts as a write (write-through pulse if WR_THRU=1).
REQ-033 An address is always in range because DEPTH = 2**ADDR_W, so no wrap or bound check is needed.

Reset
REQ-034 With rst_n=0 at a rising edge: dataout=0, dout_valid=0, err=0, busy=1, state=CLEAR, ptr=0.
REQ-035 Reset asserted mid-sweep or mid-access SHALL abort it; the sweep then restarts from address 0 after release.
REQ-036 Memory contents are undefined only until the sweep completes; after that, every word reads 0.

Verification
REQ-037 Release reset, count cycles -> busy high for exactly 256 cycles; then read addresses 0, 128, 255 -> 0x0000 each.
REQ-038 Write 0xBEEF to 0x10 with be=2'b11, then next cycle read 0x10 -> dataout=0xBEEF with dout_valid one cycle after the read edge; with WR_THRU=1, dataout=0xBEEF right after the write.
REQ-039 Memory holds 0xBEEF at 0x10; write 0x1234 with be=2'b01, then read -> 0xBE34.
REQ-040 en=write=read=1 at 0x10 -> err=2'b01, mem[0x10] unchanged, dataout holds; pulse err_clr -> err=2'b00.
REQ-041 Pulse clr, then issue a read on the next cycle -> read dropped, err[1]=1, busy for 256 cycles, then mem[0x10]=0x0000.
REQ-042 Assert rst_n=0 during the sweep at ptr=100 -> outputs return to their reset values, and the sweep restarts at 0 with 256 busy cycles.

Source files
------------

// File: rtl/ram_sp_param.sv
// Single-port byte-enabled RAM with a power-on zero-fill sweep,
// optional write-through data output and sticky error flags.
module ram_sp_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int WR_THRU = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                write,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   datain,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    input  logic                err_clr,
    output logic [DATA_W-1:0]   dataout,
    output logic                dout_valid,
    output logic                busy,
    output logic [1:0]          err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   cur, merged;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                load;
    logic [DATA_W-1:0]   load_data;
    logic [1:0]          err_set;
    logic                req;

    assign busy = (state == CLEAR);
    assign req  = en & (write | read);
    assign cur  = mem[address];

    always_comb begin
        merged = cur;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = datain[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = merged;
        load      = 1'b0;
        load_data = merged;
        err_set   = 2'b00;
        unique case (state)
            CLEAR: begin
                // clr is deliberately ignored so the sweep never restarts
                mem_we     = 1'b1;
                mem_addr   = ptr;
                mem_wdata  = '0;
                ptr_nxt    = ptr + 1'b1;
                err_set[1] = req;
                if (&ptr) state_nxt = READY;
            end
            READY: begin
                if (clr) begin
                    state_nxt  = CLEAR;
                    ptr_nxt    = '0;
                    err_set[1] = req;
                end else if (en & write & read) begin
                    err_set[0] = 1'b1;
                end else if (en & write) begin
                    mem_we = 1'b1;
                    load   = (WR_THRU != 0);
                end else if (en & read) begin
                    load      = 1'b1;
                    load_data = cur;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            ptr        <= '0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            err        <= 2'b00;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            dout_valid <= load;
            if (load) dataout <= load_data;
            // a new error on the same edge as err_clr stays set
            err <= (err_clr ? 2'b00 : err) | err_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: vector table for READY-state
// accesses plus hand sequences for sweep, clr and reset corners.
module tb_ram_sp_param;

    logic        clk = 1'b0;
    logic        rst_n, en, write, read, clr, err_clr;
    logic [7:0]  address;
    logic [15:0] datain;
    logic [1:0]  be;
    logic [15:0] dataout;
    logic        dout_valid, busy;
    logic [1:0]  err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_sp_param dut (
        .clk(clk), .rst_n(rst_n), .en(en), .write(write), .read(read),
        .address(address), .datain(datain), .be(be), .clr(clr),
        .err_clr(err_clr), .dataout(dataout), .dout_valid(dout_valid),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        en, wr, rd;
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        ec;
        logic [15:0] xd;
        logic        xv;
        logic [1:0]  xe;
    } vec_t;

    vec_t v[18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        en = 1'b0; write = 1'b0; read = 1'b0; clr = 1'b0; err_clr = 1'b0;
        address = '0; datain = '0; be = '0;
    endtask

    task automatic op(input logic e, input logic w, input logic r,
                      input logic [7:0] a, input logic [15:0] d,
                      input logic [1:0] b);
        idle();
        en = e; write = w; read = r; address = a; datain = d; be = b;
        @(negedge clk);
    endtask

    task automatic count_busy(input int clr_at, output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
            idle();
            clr = (n == clr_at);
        end
        clr = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dout"}, 32'(dataout), 32'h0);
        check({tag, "_valid"}, 32'(dout_valid), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        int n;
        v[0]  = '{1'b1,1'b0,1'b1,8'h00,16'h0000,2'b00,1'b0,16'h0000,1'b1,2'b00};
        v[1]  = '{1'b1,1'b0,1'b1,8'h80,16'h0000,2'b00,1'b0,16'h0000,1'b1,2'b00};
        v[2]  = '{1'b1,1'b0,1'b1,8'hFF,16'h0000,2'b00,1'b0,16'h0000,1'b1,2'b00};
        v[3]  = '{1'b0,1'b0,1'b1,8'h00,16'h0000,2'b00,1'b0,16'h0000,1'b0,2'b00};
        v[4]  = '{1'b1,1'b1,1'b0,8'h10,16'hBEEF,2'b11,1'b0,16'hBEEF,1'b1,2'b00};
        v[5]  = '{1'b1,1'b0,1'b1,8'h10,16'h0000,2'b00,1'b0,16'hBEEF,1'b1,2'b00};
        v[6]  = '{1'b1,1'b1,1'b0,8'h10,16'h1234,2'b01,1'b0,16'hBE34,1'b1,2'b00};
        v[7]  = '{1'b1,1'b0,1'b1,8'h10,16'h0000,2'b00,1'b0,16'hBE34,1'b1,2'b00};
        v[8]  = '{1'b1,1'b1,1'b1,8'h10,16'h0000,2'b11,1'b0,16'hBE34,1'b0,2'b01};
        v[9]  = '{1'b1,1'b0,1'b1,8'h10,16'h0000,2'b00,1'b0,16'hBE34,1'b1,2'b01};
        v[10] = '{1'b0,1'b0,1'b0,8'h00,16'h0000,2'b00,1'b1,16'hBE34,1'b0,2'b00};
        v[11] = '{1'b1,1'b1,1'b0,8'h20,16'hFFFF,2'b00,1'b0,16'h0000,1'b1,2'b00};
        v[12] = '{1'b1,1'b0,1'b1,8'h20,16'h0000,2'b00,1'b0,16'h0000,1'b1,2'b00};
        v[13] = '{1'b1,1'b0,1'b0,8'h20,16'h0000,2'b00,1'b0,16'h0000,1'b0,2'b00};
        v[14] = '{1'b1,1'b1,1'b0,8'hFF,16'hA5C3,2'b10,1'b0,16'hA500,1'b1,2'b00};
        v[15] = '{1'b1,1'b0,1'b1,8'hFF,16'h0000,2'b00,1'b0,16'hA500,1'b1,2'b00};
        v[16] = '{1'b1,1'b1,1'b1,8'hFF,16'h0000,2'b11,1'b1,16'hA500,1'b0,2'b01};
        v[17] = '{1'b0,1'b0,1'b0,8'h00,16'h0000,2'b00,1'b1,16'hA500,1'b0,2'b00};

        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");

        rst_n = 1'b1;
        count_busy(0, n);
        check("sweep_cycles", 32'(n), 32'd256);

        for (int i = 0; i < 18; i++) begin
            idle();
            en = v[i].en; write = v[i].wr; read = v[i].rd;
            address = v[i].a; datain = v[i].d; be = v[i].be;
            err_clr = v[i].ec;
            @(negedge clk);
            check($sformatf("vec%0d_dout", i), 32'(dataout), 32'(v[i].xd));
            check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(v[i].xv));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].xe));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // clr, then a read that must be dropped; mid-sweep clr ignored
        idle();
        clr = 1'b1;
        @(negedge clk);
        check("clr_busy", 32'(busy), 32'h1);
        idle();
        en = 1'b1; read = 1'b1; address = 8'h10;
        count_busy(50, n);
        check("clr_sweep_cycles", 32'(n), 32'd256);
        check("drop_err", 32'(err), 32'h2);
        check("drop_dout", 32'(dataout), 32'hA500);
        op(1'b1, 1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
        check("clr_read_10", 32'(dataout), 32'h0000);
        check("clr_read_valid", 32'(dout_valid), 32'h1);

        // clr together with a write: clr wins, write dropped
        idle();
        err_clr = 1'b1;
        @(negedge clk);
        idle();
        clr = 1'b1; en = 1'b1; write = 1'b1; address = 8'h30;
        datain = 16'h7777; be = 2'b11;
        @(negedge clk);
        check("clr_wr_err", 32'(err), 32'h2);
        check("clr_wr_valid", 32'(dout_valid), 32'h0);
        idle();
        count_busy(0, n);
        check("clr_wr_sweep", 32'(n), 32'd256);

        // reset at sweep pointer 100 aborts and restarts the sweep
        op(1'b1, 1'b1, 1'b0, 8'h40, 16'h5A5A, 2'b11);
        check("pre_rst_dout", 32'(dataout), 32'h5A5A);
        idle();
        clr = 1'b1;
        @(negedge clk);
        idle();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        rst_n = 1'b1;
        count_busy(0, n);
        check("rst_sweep_cycles", 32'(n), 32'd256);
        op(1'b1, 1'b0, 1'b1, 8'h40, 16'h0, 2'b00);
        check("rst_read_40", 32'(dataout), 32'h0000);
        check("rst_read_valid", 32'(dout_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
